// File: rtl/rgbled_dimmer_if.sv
// rtl/rgbled_dimmer_if.sv - frame-in / frame-out bundle between SPI receiver, dimmer and LED driver
interface rgbled_dimmer_if #(
  parameter int LEDS         = 8,
  parameter int BITS_PER_LED = 24
);
  logic [LEDS*BITS_PER_LED-1:0] data_in;
  logic                         data_in_rdy;
  logic [7:0]                   brightness;
  logic [LEDS*BITS_PER_LED-1:0] data_out;
  logic                         data_out_rdy;
  logic                         busy;

  modport master (
    output data_in, data_in_rdy, brightness,
    input  data_out, data_out_rdy, busy
  );

  modport slave (
    input  data_in, data_in_rdy, brightness,
    output data_out, data_out_rdy, busy
  );
endinterface

// File: rtl/rgbled_dimmer.sv
// rtl/rgbled_dimmer.sv - global-brightness scaler, one colour byte per clock, frame-at-once output
module rgbled_dimmer #(
  parameter int LEDS         = 8,
  parameter int BITS_PER_LED = 24
) (
  input  logic            clk,
  input  logic            reset,
  rgbled_dimmer_if.slave  bus
);
  localparam int W    = LEDS * BITS_PER_LED;
  localparam int N    = W / 8;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, SCALE, DONE} state_t;

  state_t          state;
  logic            s1, s2, s3;
  logic            pending;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    work;
  logic [7:0]      brightness_q;

  logic            start;
  logic [7:0]      cur_byte;
  logic [8:0]      gain;
  logic [16:0]     product;
  logic [7:0]      scaled;
  logic [8:0]      unused_bits;

  assign start = s2 & ~s3;

  // gain = brightness+1 makes 255 an exact identity and 0 a hard off
  always_comb begin
    cur_byte    = work[{idx, 3'b000} +: 8];
    gain        = {1'b0, brightness_q} + 9'd1;
    product     = {9'd0, cur_byte} * {8'd0, gain};
    scaled      = product[15:8];
    unused_bits = {product[16], product[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      s1               <= 1'b0;
      s2               <= 1'b0;
      s3               <= 1'b0;
      pending          <= 1'b0;
      idx              <= '0;
      work             <= '0;
      brightness_q     <= '0;
      bus.data_out     <= '0;
      bus.data_out_rdy <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      s1               <= bus.data_in_rdy;
      s2               <= s1;
      s3               <= s2;
      bus.data_out_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start || pending) begin
            work         <= bus.data_in;
            brightness_q <= bus.brightness;
            pending      <= 1'b0;
            idx          <= '0;
            bus.busy     <= 1'b1;
            state        <= SCALE;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        SCALE: begin
          if (start) pending <= 1'b1;
          work[{idx, 3'b000} +: 8] <= scaled;
          if (idx == LAST) state <= DONE;
          else             idx   <= idx + 1'b1;
        end
        DONE: begin
          // busy stays high through the strobe cycle; IDLE decides whether it drops
          if (start) pending <= 1'b1;
          bus.data_out     <= work;
          bus.data_out_rdy <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
